// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared widths, sector codes and saturation helper for the CORDIC output stage
package cordic_pkg;

    // Data words are signed Q7.8
    localparam int W    = 16;
    localparam int INT  = 7;
    localparam int FRAC = 8;
    localparam int SFW  = 2;

    typedef enum logic [SFW-1:0] {
        SECT_Q1 = 2'd0,
        SECT_Q2 = 2'd1,
        SECT_Q3 = 2'd2,
        SECT_Q4 = 2'd3
    } sector_e;

    // pi in Q7.8 radians
    localparam logic signed [W-1:0] PI_Q = 16'sd804;

    // Clamp a 17-bit intermediate into the signed 16-bit range
    function automatic logic signed [W-1:0] sat16(input logic signed [W:0] v);
        if (v > 17'sh0_7FFF) begin
            return 16'sh7FFF;
        end else if (v < 17'sh1_8000) begin
            return 16'sh8000;
        end else begin
            return v[W-1:0];
        end
    endfunction

endpackage

// File: rtl/cordic_output_stage_if.sv
// rtl/cordic_output_stage_if.sv - result output handshake bundle
// master: drives out_valid/out_x/out_y/out_arctan, samples out_ready
// slave : consumer side
interface cordic_output_stage_if import cordic_pkg::*; ();
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_x;
    logic [W-1:0] out_y;
    logic         out_arctan;

    modport master (output out_valid, output out_x, output out_y, output out_arctan, input out_ready);
    modport slave  (input out_valid, input out_x, input out_y, input out_arctan, output out_ready);
endinterface

// File: rtl/cordic_out_fifo.sv
// rtl/cordic_out_fifo.sv - result FIFO with occupancy count and drop indication
// Ports: clk/reset; push_i + wr_data_i; pop_i; rd_data_o (head, zero when empty);
//        empty_o, full_o, count_next_o (occupancy after this edge), drop_o (push refused).
module cordic_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CW-1:0]    count_next_o,
    output logic             drop_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok, push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

    // A full FIFO still takes a push when the head leaves on the same edge
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign drop_o  = push_i && !push_ok;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    assign count_next_o = count_d;
    assign rd_data_o    = empty_o ? '0 : mem_q[rd_ptr_q];

    // Power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/cordic_output_stage.sv
// rtl/cordic_output_stage.sv - sector restoration register plus buffered result output
// Ports: clk/reset; valid_in, arctan_en_in, sector_in, x_in, y_in, degree_in from the pipeline;
//        out_if (master) carries out_valid/out_ready/out_x/out_y/out_arctan;
//        almost_full (registered throttle), overflow (sticky drop flag).
module cordic_output_stage import cordic_pkg::*; #(
    parameter int FIFO_DEPTH        = 4,
    parameter int ALMOST_FULL_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    input  logic                     arctan_en_in,
    input  logic [SFW-1:0]           sector_in,
    input  logic [W-1:0]             x_in,
    input  logic [W-1:0]             y_in,
    input  logic [W-1:0]             degree_in,
    cordic_output_stage_if.master    out_if,
    output logic                     almost_full,
    output logic                     overflow
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = 2 * W + 1;

    logic signed [W:0]   c_ext, s_ext, a_ext, pi_ext;
    logic signed [W-1:0] rx_d, ry_d;
    logic signed [W-1:0] rx_q, ry_q;
    logic                r_valid_q, r_arctan_q;
    logic                almost_full_q, overflow_q;

    logic [EW-1:0]       head;
    logic                fifo_empty, fifo_full, fifo_drop;
    logic [CW-1:0]       count_next;

    assign c_ext  = {x_in[W-1], x_in};
    assign s_ext  = {y_in[W-1], y_in};
    assign a_ext  = {degree_in[W-1], degree_in};
    assign pi_ext = {PI_Q[W-1], PI_Q};

    // Map the first-quadrant result back into the original sector
    always_comb begin
        rx_d = x_in;
        ry_d = y_in;
        if (arctan_en_in) begin
            rx_d = x_in;
            case (sector_e'(sector_in))
                SECT_Q1: ry_d = degree_in;
                SECT_Q2: ry_d = sat16(pi_ext - a_ext);
                SECT_Q3: ry_d = sat16(a_ext - pi_ext);
                SECT_Q4: ry_d = sat16(-a_ext);
                default: ry_d = degree_in;
            endcase
        end else begin
            case (sector_e'(sector_in))
                SECT_Q1: begin rx_d = x_in;          ry_d = y_in;          end
                SECT_Q2: begin rx_d = sat16(-s_ext); ry_d = x_in;          end
                SECT_Q3: begin rx_d = sat16(-c_ext); ry_d = sat16(-s_ext); end
                SECT_Q4: begin rx_d = y_in;          ry_d = sat16(-c_ext); end
                default: begin rx_d = x_in;          ry_d = y_in;          end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_q     <= 1'b0;
            r_arctan_q    <= 1'b0;
            rx_q          <= '0;
            ry_q          <= '0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            r_valid_q     <= valid_in;
            if (valid_in) begin
                r_arctan_q <= arctan_en_in;
                rx_q       <= rx_d;
                ry_q       <= ry_d;
            end
            almost_full_q <= (int'(count_next) >= ALMOST_FULL_LEVEL);
            overflow_q    <= overflow_q | fifo_drop;
        end
    end

    cordic_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW),
        .CW    (CW)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (r_valid_q),
        .wr_data_i    ({r_arctan_q, rx_q, ry_q}),
        .pop_i        (out_if.out_ready),
        .rd_data_o    (head),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full),
        .count_next_o (count_next),
        .drop_o       (fifo_drop)
    );

    assign out_if.out_valid  = !fifo_empty;
    assign out_if.out_arctan = head[EW-1];
    assign out_if.out_x      = head[2*W-1:W];
    assign out_if.out_y      = head[W-1:0];
    assign almost_full       = almost_full_q;
    assign overflow          = overflow_q;

endmodule

// File: tb/tb_cordic_output_stage.sv
// tb/tb_cordic_output_stage.sv - scoreboard bench for cordic_output_stage
module tb_cordic_output_stage;
    import cordic_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        arctan_en_in;
    logic [1:0]  sector_in;
    logic [15:0] x_in, y_in, degree_in;
    logic        almost_full, overflow;

    always #5 clk = ~clk;

    cordic_output_stage_if oif();

    cordic_output_stage #(
        .FIFO_DEPTH        (4),
        .ALMOST_FULL_LEVEL (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .arctan_en_in (arctan_en_in),
        .sector_in    (sector_in),
        .x_in         (x_in),
        .y_in         (y_in),
        .degree_in    (degree_in),
        .out_if       (oif.master),
        .almost_full  (almost_full),
        .overflow     (overflow)
    );

    logic [32:0] sb_q[$];
    logic [32:0] mon_exp;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic arc, input logic [1:0] sec, input logic [15:0] x,
                        input logic [15:0] y, input logic [15:0] deg, input bit keep,
                        input logic [15:0] ex, input logic [15:0] ey);
        valid_in     = 1'b1;
        arctan_en_in = arc;
        sector_in    = sec;
        x_in         = x;
        y_in         = y;
        degree_in    = deg;
        if (keep) sb_q.push_back({arc, ex, ey});
        step();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) step();
        check("drain_remaining", sb_q.size(), 0);
    endtask

    // Monitor: each accepted head is compared against the oldest expected entry
    always @(negedge clk) begin
        if (!reset && oif.out_valid && oif.out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got x=%h y=%h expected none", oif.out_x, oif.out_y);
            end else begin
                mon_exp = sb_q.pop_front();
                check("out_arctan", oif.out_arctan, mon_exp[32]);
                check("out_x", oif.out_x, mon_exp[31:16]);
                check("out_y", oif.out_y, mon_exp[15:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        valid_in      = 1'b0;
        arctan_en_in  = 1'b0;
        sector_in     = 2'd0;
        x_in          = '0;
        y_in          = '0;
        degree_in     = '0;
        oif.out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;

        check("rst_out_valid", oif.out_valid, 0);
        check("rst_almost_full", almost_full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_out_x", oif.out_x, 0);
        check("rst_out_y", oif.out_y, 0);
        check("rst_out_arctan", oif.out_arctan, 0);

        // Latency: valid at edge N, out_valid after edge N+1
        oif.out_ready = 1'b1;
        send(1'b0, 2'd1, 16'h0100, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0100);
        valid_in = 1'b0;
        check("lat_after_n", oif.out_valid, 0);
        step();
        check("lat_after_n1", oif.out_valid, 1);
        drain();

        // Back-to-back stream of restoration cases
        send(1'b1, 2'd2, 16'h0200, 16'h0000, 16'h0100, 1'b1, 16'h0200, 16'hFDDC);
        send(1'b0, 2'd2, 16'h8000, 16'h0000, 16'h0000, 1'b1, 16'h7FFF, 16'h0000);
        send(1'b0, 2'd3, 16'h0100, 16'h0080, 16'h0000, 1'b1, 16'h0080, 16'hFF00);
        send(1'b0, 2'd0, 16'h1234, 16'h5678, 16'h0000, 1'b1, 16'h1234, 16'h5678);
        send(1'b1, 2'd1, 16'h0300, 16'h0000, 16'h0064, 1'b1, 16'h0300, 16'h02C0);
        send(1'b1, 2'd3, 16'h0150, 16'h0000, 16'h0192, 1'b1, 16'h0150, 16'hFE6E);
        send(1'b1, 2'd0, 16'h0111, 16'h0000, 16'h0100, 1'b1, 16'h0111, 16'h0100);
        send(1'b0, 2'd1, 16'h0010, 16'h8000, 16'h0000, 1'b1, 16'h7FFF, 16'h0010);
        send(1'b1, 2'd2, 16'h0001, 16'h0000, 16'h8000, 1'b1, 16'h0001, 16'h8000);
        send(1'b0, 2'd3, 16'h8000, 16'h0005, 16'h0000, 1'b1, 16'h0005, 16'h7FFF);
        valid_in = 1'b0;
        drain();

        // Stalled consumer: fill, overflow, head hold, then ordered drain
        oif.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(1'b0, 2'd0, 16'(i + 1), 16'(i + 17), 16'h0000, (i < 4),
                 16'(i + 1), 16'(i + 17));
            if (i == 1) check("af_after_1st_write", almost_full, 0);
            if (i == 2) check("af_after_2nd_write", almost_full, 1);
            if (i == 4) check("ovf_before_drop", overflow, 0);
        end
        valid_in = 1'b0;
        step();
        check("ovf_after_drop", overflow, 1);
        check("stall_out_valid", oif.out_valid, 1);
        check("stall_head_x", oif.out_x, 16'h0001);
        step();
        step();
        check("stall_head_hold_x", oif.out_x, 16'h0001);
        check("stall_head_hold_y", oif.out_y, 16'h0011);
        check("ovf_sticky", overflow, 1);
        oif.out_ready = 1'b1;
        drain();
        check("ovf_sticky_after_drain", overflow, 1);

        reset = 1'b1;
        step();
        reset = 1'b0;
        check("ovf_cleared_by_reset", overflow, 0);

        // Full FIFO with simultaneous push and pop every cycle
        oif.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) oif.out_ready = 1'b1;
            send(1'b1, 2'd1, 16'(16'h0100 + i), 16'h0000, 16'(i * 10), 1'b1,
                 16'(16'h0100 + i), 16'(804 - i * 10));
            if (i >= 4) begin
                check("full_out_valid", oif.out_valid, 1);
                check("full_almost_full", almost_full, 1);
                check("full_no_overflow", overflow, 0);
            end
        end
        valid_in = 1'b0;
        drain();
        check("full_ovf_end", overflow, 0);

        // Reset with entries queued discards them
        oif.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 2'd2, 16'(i + 1), 16'h0000, 16'h0000, 1'b1, 16'(-(i + 1)), 16'h0000);
        end
        valid_in = 1'b0;
        step();
        check("q3_out_valid", oif.out_valid, 1);
        check("q3_almost_full", almost_full, 1);
        reset = 1'b1;
        step();
        check("midrst_out_valid", oif.out_valid, 0);
        check("midrst_almost_full", almost_full, 0);
        check("midrst_overflow", overflow, 0);
        sb_q.delete();
        reset = 1'b0;
        oif.out_ready = 1'b1;
        send(1'b0, 2'd3, 16'h0040, 16'h0020, 16'h0000, 1'b1, 16'h0020, 16'hFFC0);
        valid_in = 1'b0;
        drain();
        step();
        check("final_out_valid", oif.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
